// File: rtl/lsu_fsm.sv
`default_nettype none
// ============================================================================
// Module      : lsu_fsm
// Description : Multi-cycle load/store unit with a req/gnt + rvalid bus,
//               store lane replication, load extension and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_fsm #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_REQ     = 2'd1;
    localparam logic [1:0]  c_WAIT    = 2'd2;
    localparam logic [1:0]  c_RESP    = 2'd3;
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state, w_state_nxt;
    logic        r_write, w_write_nxt;
    logic [2:0]  r_op,    w_op_nxt;
    logic [31:0] r_addr,  w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_err,   w_err_nxt;
    logic [15:0] r_cnt,   w_cnt_nxt;

    logic        w_bad_op;
    logic        w_timeout;
    logic [15:0] w_lane;
    logic [31:0] w_load;

    // Illegal encodings and misaligned accesses never reach the bus
    always_comb begin
        w_bad_op = req_write ? (req_op[2] | (req_op[1:0] == 2'b11))
                             : ((req_op[1:0] == 2'b11) | (req_op[2] & req_op[1]));
        if ((req_op[1:0] == 2'b01) && req_addr[0])
            w_bad_op = 1'b1;
        if ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
            w_bad_op = 1'b1;
    end

    assign w_timeout = (r_cnt >= c_TO_LAST);
    assign w_lane    = 16'(mem_rdata >> {r_addr[1:0], 3'b000});

    always_comb begin
        case (r_op)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane};
            3'b101:  w_load = {16'd0, w_lane};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        case (r_op[1:0])
            2'b00: begin
                mem_wdata = {4{r_wdata[7:0]}};
                mem_wmask = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                mem_wdata = {2{r_wdata[15:0]}};
                mem_wmask = 4'b0011 << r_addr[1:0];
            end
            default: begin
                mem_wdata = r_wdata;
                mem_wmask = 4'b1111;
            end
        endcase
        if (!r_write)
            mem_wmask = 4'b0000;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = r_write;
        w_op_nxt    = r_op;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    w_write_nxt = req_write;
                    w_op_nxt    = req_op;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    w_rdata_nxt = 32'd0;
                    w_err_nxt   = w_bad_op;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = w_bad_op ? c_RESP : c_REQ;
                end
            end
            c_REQ: begin
                w_cnt_nxt = r_cnt + 16'd1;
                // A grant in the timeout cycle still wins
                if (mem_gnt) begin
                    w_state_nxt = r_write ? c_RESP : c_WAIT;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_RESP;
                end
            end
            c_WAIT: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (mem_rvalid) begin
                    w_rdata_nxt = w_load;
                    w_state_nxt = c_RESP;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_RESP;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_op    <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_write <= w_write_nxt;
            r_op    <= w_op_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = (r_state == c_RESP);
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = r_rdata;
    assign mem_req    = (r_state == c_REQ);
    assign mem_we     = r_write;
    assign mem_addr   = {r_addr[31:2], 2'b00};

endmodule
`default_nettype wire
